// File: rtl/noc_vc_buffer_pkg.sv
// Shared definitions for the per-VC input buffer: flit width, buffer entry layout
// and input packet tracker state encoding.
`ifndef Noc_Data_Width
`define Noc_Data_Width 32
`endif
`ifndef Noc_VC_Channel
`define Noc_VC_Channel 4
`endif

package noc_vc_buffer_pkg;

    localparam int unsigned FlitW = `Noc_Data_Width;

    // Input packet tracker states
    typedef enum logic {
        InIdle = 1'b0,
        InPkt  = 1'b1
    } in_state_e;

    // One buffer slot: payload plus its framing markers
    typedef struct packed {
        logic             is_header;
        logic             is_tail;
        logic [FlitW-1:0] flit;
    } flit_entry_t;

endpackage

// File: rtl/noc_vc_buffer_if.sv
// Handshake bundle between the VC allocator, the VC buffer and the switch stage.
interface noc_vc_buffer_if;
    import noc_vc_buffer_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [FlitW-1:0] in_flit;
    logic             in_is_header;
    logic             in_is_tail;
    logic             in_vcready;
    logic             out_valid;
    logic             out_ready;
    logic [FlitW-1:0] out_flit;
    logic             out_is_header;
    logic             out_is_tail;
    logic             pkt_avail;
    logic             proto_err;

    // Allocator/switch side
    modport master (
        output in_valid, in_flit, in_is_header, in_is_tail, out_ready,
        input  in_ready, in_vcready, out_valid, out_flit, out_is_header, out_is_tail,
        input  pkt_avail, proto_err
    );

    // Buffer side
    modport slave (
        input  in_valid, in_flit, in_is_header, in_is_tail, out_ready,
        output in_ready, in_vcready, out_valid, out_flit, out_is_header, out_is_tail,
        output pkt_avail, proto_err
    );

endinterface

// File: rtl/noc_vc_fifo_mem.sv
// Flit storage array with wrap-bit pointers; show-ahead read of the head slot.
module noc_vc_fifo_mem
    import noc_vc_buffer_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push,
    input  logic          pop,
    input  flit_entry_t   wdata,
    output flit_entry_t   rdata,
    output logic [PTR_W:0] count,
    output logic          full,
    output logic          empty
);

    localparam logic [PTR_W:0] PtrOne = (PTR_W + 1)'(1);

    flit_entry_t    mem [DEPTH];
    logic [PTR_W:0] wr_ptr_q, rd_ptr_q;

    // Pointer advance and storage write; storage is cleared so the head reads zero after reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (push) begin
                mem[wr_ptr_q[PTR_W-1:0]] <= wdata;
                wr_ptr_q                 <= wr_ptr_q + PtrOne;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrOne;
            end
        end
    end

    assign count = wr_ptr_q - rd_ptr_q;
    assign empty = (wr_ptr_q == rd_ptr_q);
    // Same slot index but different lap means every slot is occupied
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign rdata = mem[rd_ptr_q[PTR_W-1:0]];

endmodule

// File: rtl/noc_vc_buffer.sv
// Per-VC input buffer: stores flits with framing, tracks packet boundaries, returns a
// packet-granular VC ready and flags framing errors.
// Optional NOC_VCBUF_OCCUPANCY_EN exposes occupancy and stored-packet count ports.
module noc_vc_buffer
    import noc_vc_buffer_pkg::*;
#(
    parameter int unsigned DEPTH         = 8,
    parameter int unsigned PKT_MAX_FLITS = 4,
    localparam int unsigned PTR_W        = $clog2(DEPTH)
) (
    input  logic           noc_clk,
    input  logic           noc_rst_n,
    noc_vc_buffer_if.slave bus
`ifdef NOC_VCBUF_OCCUPANCY_EN
    ,
    output logic [PTR_W:0] occupancy,
    output logic [PTR_W:0] pkt_count
`endif
);

    localparam logic [PTR_W:0] DepthW  = (PTR_W + 1)'(DEPTH);
    localparam logic [PTR_W:0] PktMaxW = (PTR_W + 1)'(PKT_MAX_FLITS);
    localparam logic [PTR_W:0] CntOne  = (PTR_W + 1)'(1);

    flit_entry_t    wdata, rdata;
    logic [PTR_W:0] count, free_slots;
    logic [PTR_W:0] pkt_cnt_q, pkt_cnt_d;
    logic           full, empty, push, pop, tail_in, tail_out;
    in_state_e      state_q, state_d;
    logic           proto_err_q, proto_err_d;

    noc_vc_fifo_mem #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_fifo (
        .clk   (noc_clk),
        .rst_n (noc_rst_n),
        .push  (push),
        .pop   (pop),
        .wdata (wdata),
        .rdata (rdata),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign push     = bus.in_valid & ~full;
    assign pop      = ~empty & bus.out_ready;
    assign tail_in  = push & bus.in_is_tail;
    assign tail_out = pop & rdata.is_tail;
    assign wdata    = '{is_header: bus.in_is_header, is_tail: bus.in_is_tail, flit: bus.in_flit};

    assign bus.in_ready      = ~full;
    assign bus.out_valid     = ~empty;
    assign bus.out_flit      = rdata.flit;
    assign bus.out_is_header = rdata.is_header;
    assign bus.out_is_tail   = rdata.is_tail;
    assign bus.pkt_avail     = (pkt_cnt_q != '0);
    assign bus.proto_err     = proto_err_q;

`ifdef NOC_VCBUF_OCCUPANCY_EN
    assign occupancy = count;
    assign pkt_count = pkt_cnt_q;
`endif

    // State, sticky error and stored-packet counter registers
    always_ff @(posedge noc_clk or negedge noc_rst_n) begin
        if (!noc_rst_n) begin
            state_q     <= InIdle;
            proto_err_q <= 1'b0;
            pkt_cnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            proto_err_q <= proto_err_d;
            pkt_cnt_q   <= pkt_cnt_d;
        end
    end

    // Tracker follows the framing bits even on a violation; violations only set the flag
    always_comb begin
        state_d     = state_q;
        proto_err_d = proto_err_q;
        if (push) begin
            unique case (state_q)
                InIdle: begin
                    if (!bus.in_is_header) proto_err_d = 1'b1;
                    if (bus.in_is_header && !bus.in_is_tail) state_d = InPkt;
                end
                InPkt: begin
                    if (bus.in_is_header) proto_err_d = 1'b1;
                    if (bus.in_is_tail) state_d = InIdle;
                end
            endcase
        end
    end

    // VC ready: mid-packet any free slot suffices, a new packet must fit completely
    always_comb begin
        free_slots     = DepthW - count;
        bus.in_vcready = 1'b0;
        case (state_q)
            InPkt:   bus.in_vcready = ~full;
            default: bus.in_vcready = (free_slots >= PktMaxW);
        endcase
    end

    // Complete packets held: a tail in adds one, a tail out removes one
    always_comb begin
        pkt_cnt_d = pkt_cnt_q;
        if (tail_in && !tail_out) begin
            pkt_cnt_d = pkt_cnt_q + CntOne;
        end else if (!tail_in && tail_out) begin
            pkt_cnt_d = pkt_cnt_q - CntOne;
        end
    end

endmodule

// File: tb/tb_noc_vc_buffer.sv
// Bench for noc_vc_buffer: queue-based reference model plus scoreboard monitor on the output.
module tb_noc_vc_buffer;
    import noc_vc_buffer_pkg::*;

    localparam int unsigned DEPTH   = 8;
    localparam int unsigned PKT_MAX = 4;

    typedef struct {
        logic [FlitW-1:0] flit;
        logic             h;
        logic             t;
    } ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    noc_vc_buffer_if bus();

`ifdef NOC_VCBUF_OCCUPANCY_EN
    logic [$clog2(DEPTH):0] occupancy, pkt_count;
`endif

    noc_vc_buffer #(
        .DEPTH         (DEPTH),
        .PKT_MAX_FLITS (PKT_MAX)
    ) u_dut (
        .noc_clk   (clk),
        .noc_rst_n (rst_n),
        .bus       (bus)
`ifdef NOC_VCBUF_OCCUPANCY_EN
        ,
        .occupancy (occupancy),
        .pkt_count (pkt_count)
`endif
    );

    int n_total = 0;
    int n_pass  = 0;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endfunction

    // Reference model: a queue of stored flits, the packet-open bit and the sticky error
    ent_t m_q[$];
    ent_t sb_q[$];
    logic m_inpkt = 1'b0;
    logic m_err   = 1'b0;

    always @(negedge clk) begin
        int   cnt;
        int   tails;
        logic exp_vcready;
        ent_t e;
        if (!rst_n) begin
            m_q.delete();
            sb_q.delete();
            m_inpkt = 1'b0;
            m_err   = 1'b0;
            chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
            chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
            chk("rst_in_vcready", 64'(bus.in_vcready), 64'd1);
            chk("rst_pkt_avail", 64'(bus.pkt_avail), 64'd0);
            chk("rst_proto_err", 64'(bus.proto_err), 64'd0);
            chk("rst_out_flit", 64'(bus.out_flit), 64'd0);
        end else begin
            cnt   = m_q.size();
            tails = 0;
            foreach (m_q[i]) if (m_q[i].t) tails++;
            exp_vcready = m_inpkt ? (cnt != DEPTH) : ((DEPTH - cnt) >= PKT_MAX);
            chk("in_ready", 64'(bus.in_ready), 64'(cnt != DEPTH));
            chk("out_valid", 64'(bus.out_valid), 64'(cnt != 0));
            chk("in_vcready", 64'(bus.in_vcready), 64'(exp_vcready));
            chk("pkt_avail", 64'(bus.pkt_avail), 64'(tails != 0));
            chk("proto_err", 64'(bus.proto_err), 64'(m_err));
            if (bus.in_valid && cnt != DEPTH) begin
                e.flit = bus.in_flit;
                e.h    = bus.in_is_header;
                e.t    = bus.in_is_tail;
                m_q.push_back(e);
                sb_q.push_back(e);
                if (!m_inpkt && !e.h) m_err = 1'b1;
                if (m_inpkt && e.h) m_err = 1'b1;
                m_inpkt = e.t ? 1'b0 : (m_inpkt | e.h);
            end
            if (cnt != 0 && bus.out_ready) void'(m_q.pop_front());
        end
    end

    // Monitor: every accepted output flit must match the oldest issued flit
    always @(negedge clk) begin
        ent_t e;
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (sb_q.size() == 0) begin
                n_total++;
                $display("FAIL sb_underflow: got flit 0x%0h, expected no output", bus.out_flit);
            end else begin
                e = sb_q.pop_front();
                chk("out_flit", 64'(bus.out_flit), 64'(e.flit));
                chk("out_is_header", 64'(bus.out_is_header), 64'(e.h));
                chk("out_is_tail", 64'(bus.out_is_tail), 64'(e.t));
            end
        end
    end

    // Present one flit from posedge+1 and hold it until accepted
    task automatic send(input logic [FlitW-1:0] f, input logic h, input logic t);
        logic acc;
        int   budget;
        budget           = 200;
        bus.in_valid     = 1'b1;
        bus.in_flit      = f;
        bus.in_is_header = h;
        bus.in_is_tail   = t;
        do begin
            @(negedge clk);
            acc = bus.in_ready;
            @(posedge clk);
            #1;
            budget--;
        end while (!acc && budget > 0);
        if (!acc) begin
            n_total++;
            $display("FAIL send_timeout: flit 0x%0h not accepted, expected acceptance", f);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        logic done;
        done          = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (!bus.out_valid) done = 1'b1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            n_total++;
            $display("FAIL drain_timeout: out_valid 1, expected 0");
        end
        bus.out_ready = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic        acc;
        int          len;
        int          pos;
        logic [31:0] seq;

        bus.in_valid     = 1'b0;
        bus.in_flit      = '0;
        bus.in_is_header = 1'b0;
        bus.in_is_tail   = 1'b0;
        bus.out_ready    = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(2);

        // Four-flit packet held, then a second packet fills the buffer
        send(32'hA0, 1'b1, 1'b0);
        send(32'hA1, 1'b0, 1'b0);
        send(32'hA2, 1'b0, 1'b0);
        send(32'hA3, 1'b0, 1'b1);
        @(negedge clk);
        chk("four_stored_vcready", 64'(bus.in_vcready), 64'd1);
        @(posedge clk);
        #1;
        send(32'hA4, 1'b1, 1'b0);
        send(32'hA5, 1'b0, 1'b0);
        send(32'hA6, 1'b0, 1'b0);
        send(32'hA7, 1'b0, 1'b1);
        @(negedge clk);
        chk("full_in_ready", 64'(bus.in_ready), 64'd0);
        chk("full_in_vcready", 64'(bus.in_vcready), 64'd0);
        @(posedge clk);
        #1;
        // Pop one flit: a slot frees but a whole packet still does not fit
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("one_free_in_ready", 64'(bus.in_ready), 64'd1);
        chk("one_free_in_vcready", 64'(bus.in_vcready), 64'd0);
        @(posedge clk);
        #1;
        drain();

        // Hold five flits then stream through several pointer laps
        send(32'hC0, 1'b1, 1'b0);
        send(32'hC1, 1'b0, 1'b0);
        send(32'hC2, 1'b0, 1'b0);
        send(32'hC3, 1'b0, 1'b1);
        send(32'hC4, 1'b1, 1'b1);
        bus.in_valid     = 1'b1;
        bus.in_is_header = 1'b1;
        bus.in_is_tail   = 1'b1;
        bus.out_ready    = 1'b1;
        for (int i = 0; i < 30; i++) begin
            bus.in_flit = 32'h100 + 32'(i);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        drain();

        // Single-flit packet, then a headerless flit while idle
        send(32'hB0, 1'b1, 1'b1);
        send(32'hB1, 1'b0, 1'b0);
        idle(3);
        @(negedge clk);
        chk("proto_err_sticky", 64'(bus.proto_err), 64'd1);
        @(posedge clk);
        #1;
        drain();

        // Randomised traffic; framing violations injected late in the run
        len = int'($urandom_range(1, PKT_MAX));
        pos = 0;
        seq = 32'h1000;
        for (int c = 0; c < 3000; c++) begin
            bus.in_valid     = ($urandom_range(0, 3) != 0);
            bus.in_flit      = seq;
            bus.in_is_header = (pos == 0);
            bus.in_is_tail   = (pos == len - 1);
            if (c > 2000 && $urandom_range(0, 31) == 0) bus.in_is_header = ~bus.in_is_header;
            bus.out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = bus.in_valid && bus.in_ready;
            @(posedge clk);
            #1;
            if (acc) begin
                seq++;
                pos++;
                if (pos == len) begin
                    pos = 0;
                    len = int'($urandom_range(1, PKT_MAX));
                end
            end
        end
        bus.in_valid = 1'b0;
        drain();

        // Asynchronous reset with a partial packet stored
        send(32'hD0, 1'b1, 1'b0);
        send(32'hD1, 1'b0, 1'b0);
        send(32'hD2, 1'b0, 1'b0);
        #3 rst_n = 1'b0;
        #1;
        chk("async_out_valid", 64'(bus.out_valid), 64'd0);
        chk("async_in_ready", 64'(bus.in_ready), 64'd1);
        chk("async_count", 64'(u_dut.count), 64'd0);
        chk("async_state", 64'(u_dut.state_q), 64'(InIdle));
        chk("async_out_flit", 64'(bus.out_flit), 64'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
